// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Items shared by the instruction-fetch unit:
//   fetch_state_e : fetch FSM states (IDLE / FETCH / HOLD / DROP)
//   INSTR_W       : instruction word width
//   PC_INC        : sequential PC increment
//   NOP_INSTR     : canonical RISC-V NOP encoding (addi x0,x0,0)
//   word_align()  : forces an address onto a 32-bit word boundary
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] PC_INC    = 32'd4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// ----------------------------------------------------------------------------
// if_pc_reg
// Program-counter register with next-PC selection.
// Priority: load (redirect target, word-aligned) > advance (+4) > hold.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pc <= RESET_PC)
//   load      : take the redirect target this edge
//   target    : redirect target address (low two bits are dropped)
//   advance   : step to pc + 4 this edge (modulo 2^32)
//   pc        : current program counter
// ----------------------------------------------------------------------------
module if_pc_reg
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] target,
   input  logic        advance,
   output logic [31:0] pc
);

   logic [31:0] pc_next;

   // Next-PC select: redirect wins over sequential advance.
   always_comb begin
      pc_next = pc;
      if (load) begin
         pc_next = word_align(target);
      end else if (advance) begin
         pc_next = pc + PC_INC;
      end else begin
         pc_next = pc;
      end
   end

   // PC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: issues word-aligned requests to instruction memory,
// presents one fetch packet per cycle to the IF/ID register, honours hazard
// stalls (hold buffer) and branch redirects (in-flight data is squashed).
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   stall_i             : hold the current packet and PC
//   redirect_i          : refetch from redirect_pc_i (highest priority)
//   redirect_pc_i       : redirect target
//   imem_req_o/addr_o   : memory request, address stable until ack
//   imem_ack_i/rdata_i  : memory response (may arrive in the request cycle)
//   valid_o             : fetch packet valid
//   address_o/instr_o/pc_add4_o : packet contents, zero when not valid
// Optional (macro IF_PERF_CNT_EN):
//   fetch_cnt_o : cycles with valid_o=1 and stall_i=0
//   stall_cnt_o : cycles with stall_i=1
// ----------------------------------------------------------------------------
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i,
   output logic               imem_req_o,
   output logic [31:0]        imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               valid_o,
   output logic [31:0]        address_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [31:0]        pc_add4_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_cnt_o,
   output logic [31:0]        stall_cnt_o
`endif
);

   fetch_state_e       state;
   fetch_state_e       state_next;
   logic [31:0]        pc;
   logic [INSTR_W-1:0] hold_buf;
   logic [31:0]        drop_addr;   // address of the squashed request still owed an ack
   logic               pc_advance;

   if_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (redirect_i),
      .target  (redirect_pc_i),
      .advance (pc_advance),
      .pc      (pc)
   );

   // Sequential advance happens only when a packet is consumed without stall.
   always_comb begin
      pc_advance = 1'b0;
      if (redirect_i) begin
         pc_advance = 1'b0;
      end else if (state == FETCH) begin
         pc_advance = imem_ack_i & ~stall_i;
      end else if (state == HOLD) begin
         pc_advance = ~stall_i;
      end else begin
         pc_advance = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; redirect outranks stall and ack.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            if (redirect_i) begin
               // Without an ack the memory still owes us a word that must be discarded.
               if (imem_ack_i) begin
                  state_next = FETCH;
               end else begin
                  state_next = DROP;
               end
            end else if (imem_ack_i && stall_i) begin
               state_next = HOLD;
            end else begin
               state_next = FETCH;
            end
         end
         HOLD: begin
            if (redirect_i || !stall_i) begin
               state_next = FETCH;
            end else begin
               state_next = HOLD;
            end
         end
         DROP: begin
            if (!redirect_i && imem_ack_i) begin
               state_next = FETCH;
            end else begin
               state_next = DROP;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Hold buffer and squashed-request address.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_buf  <= {INSTR_W{1'b0}};
         drop_addr <= 32'd0;
      end else begin
         if (state == FETCH && !redirect_i && imem_ack_i && stall_i) begin
            hold_buf <= imem_rdata_i;
         end else if (state == HOLD && redirect_i) begin
            hold_buf <= {INSTR_W{1'b0}};
         end
         if (state == FETCH && redirect_i && !imem_ack_i) begin
            drop_addr <= pc;
         end
      end
   end

   // FSM outputs; packet fields are forced to zero whenever valid_o is low.
   always_comb begin
      imem_req_o  = 1'b0;
      imem_addr_o = 32'd0;
      valid_o     = 1'b0;
      address_o   = 32'd0;
      instr_o     = {INSTR_W{1'b0}};
      pc_add4_o   = 32'd0;
      case (state)
         IDLE: begin
            imem_req_o = 1'b0;
         end
         FETCH: begin
            imem_req_o  = 1'b1;
            imem_addr_o = pc;
            if (imem_ack_i && !redirect_i) begin
               valid_o   = 1'b1;
               address_o = pc;
               instr_o   = imem_rdata_i;
               pc_add4_o = pc + PC_INC;
            end else begin
               valid_o = 1'b0;
            end
         end
         HOLD: begin
            if (!redirect_i) begin
               valid_o   = 1'b1;
               address_o = pc;
               instr_o   = hold_buf;
               pc_add4_o = pc + PC_INC;
            end else begin
               valid_o = 1'b0;
            end
         end
         DROP: begin
            imem_req_o  = 1'b1;
            imem_addr_o = drop_addr;
         end
         default: begin
            imem_req_o = 1'b0;
         end
      endcase
   end

`ifdef IF_PERF_CNT_EN
   // Free-running performance counters, wrapping on overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_o <= 32'd0;
         stall_cnt_o <= 32'd0;
      end else begin
         if (valid_o && !stall_i) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         end
         if (stall_i) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit (RESET_PC = 32'h100). Directed
// scenarios plus a randomized run against a behavioural fetch model and a
// variable-latency instruction memory. Build with IF_PERF_CNT_EN to also
// check the performance counters.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        ack = 1'b0;
   logic [31:0] rdata = 32'd0;
   logic        req;
   logic [31:0] addr;
   logic        valid;
   logic [31:0] address;
   logic [31:0] instr;
   logic [31:0] pc_add4;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch_unit #(
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_ack_i    (ack),
      .imem_rdata_i  (rdata),
      .valid_o       (valid),
      .address_o     (address),
      .instr_o       (instr),
      .pc_add4_o     (pc_add4)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o   (fetch_cnt),
      .stall_cnt_o   (stall_cnt)
`endif
   );

   // Memory contents: a fixed address-dependent pattern.
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ NOP_INSTR;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset shortly after an edge; the following cycle is the IDLE cycle.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; ack = 1'b0; stall = 1'b0; redirect = 1'b0;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      #12;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", req); end
      checks++; if (addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", valid); end
      checks++; if (address !== 32'd0) begin errors++; $display("FAIL reset_address got %0h want 0", address); end
      checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %0h want 0", instr); end
      checks++; if (pc_add4 !== 32'd0) begin errors++; $display("FAIL reset_pc_add4 got %0h want 0", pc_add4); end
`ifdef IF_PERF_CNT_EN
      checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_fetch_cnt got %0h want 0", fetch_cnt); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0h want 0", stall_cnt); end
`endif
      stall = 1'b0; redirect = 1'b0; ack = 1'b0;
   endtask

   task automatic test_zero_wait();
      logic [31:0] e;
      do_reset();
      ack = 1'b1; rdata = 32'd0;
      #3;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL zw_idle_req got %0h want 0", req); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zw_idle_valid got %0h want 0", valid); end
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         e = 32'h100 + 32'(4 * i);
         rdata = mem_data(addr);
         #3;
         checks++; if (req !== 1'b1 || addr !== e) begin errors++; $display("FAIL zw_req req %0h addr %0h want 1 %0h", req, addr, e); end
         checks++; if (valid !== 1'b1 || address !== e) begin errors++; $display("FAIL zw_pkt valid %0h address %0h want 1 %0h", valid, address, e); end
         checks++; if (instr !== mem_data(e) || pc_add4 !== e + 32'd4) begin errors++; $display("FAIL zw_data instr %0h add4 %0h want %0h %0h", instr, pc_add4, mem_data(e), e + 32'd4); end
         next_cycle();
      end
   endtask

   task automatic test_stall();
      do_reset();
      ack = 1'b1;
      next_cycle();
      stall = 1'b0; rdata = mem_data(addr);
      #3;
      checks++; if (address !== 32'h100) begin errors++; $display("FAIL st_first address %0h want 100", address); end
      next_cycle();
      stall = 1'b1; rdata = mem_data(addr);
      #3;
      checks++; if (req !== 1'b1 || valid !== 1'b1 || address !== 32'h104) begin errors++; $display("FAIL st_ack req %0h valid %0h address %0h want 1 1 104", req, valid, address); end
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         stall = (k < 2); rdata = 32'hBAD0_0000 | 32'(k);
         #3;
         checks++; if (req !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL st_hold_ctl req %0h valid %0h want 0 1", req, valid); end
         checks++; if (address !== 32'h104 || instr !== mem_data(32'h104) || pc_add4 !== 32'h108) begin errors++; $display("FAIL st_hold_pkt address %0h instr %0h add4 %0h want 104 %0h 108", address, instr, pc_add4, mem_data(32'h104)); end
         next_cycle();
      end
      stall = 1'b0; rdata = mem_data(addr);
      #3;
      checks++; if (req !== 1'b1 || addr !== 32'h108 || valid !== 1'b1) begin errors++; $display("FAIL st_resume req %0h addr %0h valid %0h want 1 108 1", req, addr, valid); end
      next_cycle();
   endtask

   task automatic test_redirect_ack();
      do_reset();
      next_cycle();
      ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0010; rdata = mem_data(addr);
      #3;
      checks++; if (valid !== 1'b0 || address !== 32'd0 || instr !== 32'd0) begin errors++; $display("FAIL ra_squash valid %0h address %0h instr %0h want 0 0 0", valid, address, instr); end
      next_cycle();
      redirect = 1'b0; rdata = mem_data(addr);
      #3;
      checks++; if (req !== 1'b1 || addr !== 32'h10 || valid !== 1'b1) begin errors++; $display("FAIL ra_target req %0h addr %0h valid %0h want 1 10 1", req, addr, valid); end
      next_cycle();
   endtask

   task automatic test_redirect_drop();
      do_reset();
      next_cycle();
      ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0010; rdata = mem_data(addr);
      next_cycle();
      // Fetch at 0x10 with three-cycle latency; redirect lands in its first cycle.
      ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2002;
      #3;
      checks++; if (req !== 1'b1 || addr !== 32'h10 || valid !== 1'b0) begin errors++; $display("FAIL rd_c1 req %0h addr %0h valid %0h want 1 10 0", req, addr, valid); end
      next_cycle();
      redirect = 1'b0;
      #3;
      checks++; if (req !== 1'b1 || addr !== 32'h10 || valid !== 1'b0) begin errors++; $display("FAIL rd_c2 req %0h addr %0h valid %0h want 1 10 0", req, addr, valid); end
      next_cycle();
      ack = 1'b1; rdata = mem_data(32'h10);
      #3;
      checks++; if (req !== 1'b1 || addr !== 32'h10 || valid !== 1'b0 || instr !== 32'd0) begin errors++; $display("FAIL rd_c3 req %0h addr %0h valid %0h instr %0h want 1 10 0 0", req, addr, valid, instr); end
      next_cycle();
      rdata = mem_data(addr);
      #3;
      checks++; if (addr !== 32'h2000 || valid !== 1'b1 || address !== 32'h2000 || instr !== mem_data(32'h2000)) begin errors++; $display("FAIL rd_new addr %0h valid %0h address %0h instr %0h want 2000 1 2000 %0h", addr, valid, address, instr, mem_data(32'h2000)); end
      next_cycle();
   endtask

   task automatic test_hold_redirect();
      do_reset();
      next_cycle();
      ack = 1'b1; stall = 1'b1; rdata = mem_data(addr);
      next_cycle();
      redirect = 1'b1; redirect_pc = 32'h0000_0300;
      #3;
      checks++; if (valid !== 1'b0 || req !== 1'b0 || instr !== 32'd0) begin errors++; $display("FAIL hr_squash valid %0h req %0h instr %0h want 0 0 0", valid, req, instr); end
      next_cycle();
      redirect = 1'b0; stall = 1'b0; rdata = mem_data(addr);
      #3;
      checks++; if (addr !== 32'h300 || valid !== 1'b1 || instr !== mem_data(32'h300)) begin errors++; $display("FAIL hr_target addr %0h valid %0h instr %0h want 300 1 %0h", addr, valid, instr, mem_data(32'h300)); end
      next_cycle();
   endtask

   task automatic test_wrap();
      do_reset();
      next_cycle();
      ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; rdata = mem_data(addr);
      next_cycle();
      redirect = 1'b0; rdata = mem_data(addr);
      #3;
      checks++; if (address !== 32'hFFFF_FFFC || pc_add4 !== 32'd0 || valid !== 1'b1) begin errors++; $display("FAIL wr_top address %0h add4 %0h valid %0h want fffffffc 0 1", address, pc_add4, valid); end
      next_cycle();
      rdata = mem_data(addr);
      #3;
      checks++; if (addr !== 32'd0 || address !== 32'd0 || pc_add4 !== 32'd4) begin errors++; $display("FAIL wr_zero addr %0h address %0h add4 %0h want 0 0 4", addr, address, pc_add4); end
      next_cycle();
   endtask

   task automatic test_async_reset();
      do_reset();
      next_cycle();
      ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0500; stall = 1'b1;
      next_cycle();
      redirect = 1'b0;
      #3;
      checks++; if (req !== 1'b1 || addr !== 32'h100) begin errors++; $display("FAIL ar_drop req %0h addr %0h want 1 100", req, addr); end
      #1;
      rst = 1'b1; ack = 1'b1;
      #1;
      checks++; if (req !== 1'b0 || addr !== 32'd0 || valid !== 1'b0) begin errors++; $display("FAIL ar_now req %0h addr %0h valid %0h want 0 0 0", req, addr, valid); end
`ifdef IF_PERF_CNT_EN
      checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt fetch %0h stall %0h want 0 0", fetch_cnt, stall_cnt); end
`endif
      next_cycle();
      rst = 1'b0; stall = 1'b0;
      #3;
      checks++; if (req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL ar_idle req %0h valid %0h want 0 0", req, valid); end
      next_cycle();
      rdata = mem_data(addr);
      #3;
      checks++; if (addr !== 32'h100 || valid !== 1'b1 || address !== 32'h100) begin errors++; $display("FAIL ar_resume addr %0h valid %0h address %0h want 100 1 100", addr, valid, address); end
      next_cycle();
   endtask

   // Randomized run. The model tracks: whether the first post-reset cycle has
   // passed, the PC, an optionally held packet, and an optional squashed
   // request still waiting for its ack at an old address.
   task automatic test_random();
      logic        m_warm, m_have, m_squash;
      logic [31:0] m_pc, m_held, m_old;
      logic [31:0] m_fcnt, m_scnt;
      logic        e_req, e_valid;
      logic [31:0] e_addr, e_address, e_instr, e_add4;
      int          wait_cnt, lat;
      do_reset();
      m_warm = 1'b0; m_have = 1'b0; m_squash = 1'b0;
      m_pc = 32'h100; m_held = 32'd0; m_old = 32'd0; m_fcnt = 32'd0; m_scnt = 32'd0;
      wait_cnt = 0; lat = int'($urandom_range(0, 3));
      for (int n = 0; n < 3000; n++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 7) == 0);
         redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         ack         = req && (wait_cnt >= lat);
         rdata       = ack ? mem_data(addr) : $urandom;
         e_req     = m_warm && !m_have;
         e_addr    = e_req ? (m_squash ? m_old : m_pc) : 32'd0;
         e_valid   = m_warm && !redirect && (m_have || (!m_squash && ack));
         e_address = e_valid ? m_pc : 32'd0;
         e_instr   = e_valid ? (m_have ? m_held : rdata) : 32'd0;
         e_add4    = e_valid ? m_pc + 32'd4 : 32'd0;
         #3;
         checks++; if (req !== e_req || addr !== e_addr) begin errors++; $display("FAIL rnd_req n=%0d req %0h addr %0h want %0h %0h", n, req, addr, e_req, e_addr); end
         checks++; if (valid !== e_valid || address !== e_address) begin errors++; $display("FAIL rnd_valid n=%0d valid %0h address %0h want %0h %0h", n, valid, address, e_valid, e_address); end
         checks++; if (instr !== e_instr || pc_add4 !== e_add4) begin errors++; $display("FAIL rnd_pkt n=%0d instr %0h add4 %0h want %0h %0h", n, instr, pc_add4, e_instr, e_add4); end
`ifdef IF_PERF_CNT_EN
         checks++; if (fetch_cnt !== m_fcnt || stall_cnt !== m_scnt) begin errors++; $display("FAIL rnd_cnt n=%0d fetch %0h stall %0h want %0h %0h", n, fetch_cnt, stall_cnt, m_fcnt, m_scnt); end
`endif
         // Memory: a completed or cancelled request restarts the latency count.
         if (req && ack) begin
            wait_cnt = 0; lat = int'($urandom_range(0, 3));
         end else if (req) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
         end
         if (e_valid && !stall) m_fcnt = m_fcnt + 32'd1;
         if (stall) m_scnt = m_scnt + 32'd1;
         if (!m_warm) begin
            m_warm = 1'b1;
            if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (redirect) begin
            if (!m_squash && !m_have && !ack) begin
               m_squash = 1'b1; m_old = m_pc;
            end
            m_have = 1'b0;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (m_squash) begin
            if (ack) m_squash = 1'b0;
         end else if (m_have) begin
            if (!stall) begin
               m_have = 1'b0; m_pc = m_pc + 32'd4;
            end
         end else if (ack) begin
            if (stall) begin
               m_have = 1'b1; m_held = rdata;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_ack();
      test_redirect_drop();
      test_hold_redirect();
      test_wrap();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
